mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory bus interface that sits directly downstream of the CPU core and in front of the external memory model. It accepts instruction-fetch and data-access requests from the core and serialises them onto the single shared bus (readM, writeM, address, bidirectional data). It runs the inputReady/ackOutput handshake and returns registered instruction and load data with one-cycle completion pulses.

## Interface
- TIMEOUT_CYCLES, 16: bus cycles allowed per transaction before abort; legal range 1..255; used only with the timeout feature.
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_req  in  1  instruction-fetch request, level-sampled in IDLE.
- fetch_addr  in  16  fetch address (PC).
- fetch_valid  out  1  one-cycle pulse; instr holds new word.
- instr  out  16  last fetched instruction, held until next fetch completes.
- data_req  in  1  data-access request, level-sampled in IDLE.
- data_we  in  1  1 = store, 0 = load.
- data_addr  in  16  load/store address.
- data_wdata  in  16  store data.
- data_done  out  1  one-cycle pulse; load/store finished.
- data_rdata  out  16  last load result, held.
- busy  out  1  high whenever state is not IDLE.
- mem_err  out  1  one-cycle pulse on timeout abort (constant 0 without the timeout feature).
- readM  out  1  memory read strobe.
- writeM  out  1  memory write strobe.
- address  out  16  bus address.
- data  inout  16  bus data; driven only during a write.
- inputReady  in  1  memory read data valid.
- ackOutput  in  1  memory write accepted.

## Operation
- States: IDLE, RD, WR. Transaction kind (fetch/load) is held in a registered flag.
- IDLE: if data_req=1, latch data_addr, data_wdata and data_we; go to WR if data_we=1, else RD (kind=load). Else if fetch_req=1, latch fetch_addr; go to RD (kind=fetch). Else stay in IDLE.
- Priority: when both requests are high in the same cycle, data wins. The data access belongs to the instruction already fetched.
- Request inputs are ignored outside IDLE. The core may drop them once busy rises.
- RD: readM=1 and address=latched address. On a rising edge with inputReady=1, capture data into instr (fetch) or data_rdata (load), then go to IDLE. inputReady is ignored outside RD.
- WR: writeM=1, address=latched address, and data is driven with the latched wdata. On ackOutput=1, go to IDLE. ackOutput is ignored outside WR.
- data is high-Z in every state except WR.
- readM, writeM and address are registered state decodes; they never glitch. address is 0 in IDLE.
- A request still high in the cycle carrying the done pulse counts as a new request.

## Timing
- Reset (async assert): state=IDLE; readM=writeM=busy=0; fetch_valid=data_done=mem_err=0; address=0; instr=0; data_rdata=0; data=Z.
- Reset mid-transaction aborts it immediately. No completion pulse is issued and latched data is lost.
- Request sampled at edge N: strobe is high from N+1.
- Handshake sampled at edge K: the strobe drops and the completion pulse is high during cycle K+1.
- Minimum latency (handshake in the first strobe cycle): request edge to pulse = 2 cycles. A new request is accepted at the end of the pulse cycle, giving a 2-cycle-per-access throughput.
- Pulses are exactly one cycle wide. fetch_valid and data_done are never high together.

## Configuration
- MEM_TIMEOUT_EN defined:
  - An 8-bit counter clears on entry to RD/WR and increments each cycle in RD/WR.
  - When the count reaches TIMEOUT_CYCLES with no handshake, the unit returns to IDLE and pulses mem_err together with the normal completion pulse.
  - instr and data_rdata are left unchanged on an abort.
  - A handshake on the same edge as expiry counts as success (no error).
- MEM_TIMEOUT_EN undefined: no counter is present, mem_err is tied to 0, and the unit waits indefinitely for the handshake.

## Structure
- Shared header: WORD_SIZE (existing opcodes header), state encodings, and the default TIMEOUT_CYCLES constant.
- One sub-module, mem_timeout_counter (clear/enable/expire), instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Fetch: fetch_req=1, fetch_addr=0x0010; memory returns 0x6A01 with inputReady after 3 cycles. Required: readM high for 3 cycles, address=0x0010, then fetch_valid pulse with instr=0x6A01.
- Store: data_req=1, data_we=1, addr=0x0040, wdata=0xBEEF; ackOutput after 2 cycles. Required: writeM high, bus carries 0xBEEF only while writeM is high, then data_done pulse.
- Collision: fetch_req and data_req (load from 0x0041) asserted together. Required: the load at 0x0041 completes first, then the fetch proceeds; data_rdata and instr are correct.
- Reset while in RD with inputReady pending. Required: all outputs at reset values immediately, data=Z, no pulse after reset release.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no inputReady. Required: readM high for 4 cycles, then mem_err and fetch_valid pulse together, with instr unchanged.
- MEM_TIMEOUT_EN, inputReady on the expiry edge. Required: successful capture with mem_err=0.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for mem_access_unit: word size, FSM encodings, latched request
// payload and the default bus-timeout budget.
package mem_access_unit_pkg;

   localparam int unsigned WORD_SIZE          = 16;
   localparam int unsigned TIMEOUT_CYCLES_DEF = 16;
   localparam int unsigned TCNT_W             = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RD   = 2'd1,
      ST_WR   = 2'd2
   } state_e;

   typedef enum logic {
      KIND_FETCH = 1'b0,
      KIND_LOAD  = 1'b1
   } kind_e;

   typedef struct packed {
      logic [WORD_SIZE-1:0] addr;
      logic [WORD_SIZE-1:0] wdata;
   } bus_req_t;

endpackage

// File: rtl/mem_access_unit_timeout_counter.sv
// Per-transaction bus cycle counter; expire_c flags the last strobe cycle allowed.
module mem_timeout_counter
   import mem_access_unit_pkg::*;
#(
   parameter int unsigned LIMIT = TIMEOUT_CYCLES_DEF
)
(
   input  logic clk,
   input  logic reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_c
);

   logic [TCNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + TCNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // The edge that would bring the count to LIMIT is the abort edge.
   assign expire_c = en_i && (cnt_q == TCNT_W'(LIMIT - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Serialises instruction fetches and data accesses onto a single shared memory bus.
// Optional bus timeout with mem_err reporting is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
   import mem_access_unit_pkg::*;
`ifdef MEM_TIMEOUT_EN
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
)
`endif
(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 fetch_req,
   input  logic [WORD_SIZE-1:0] fetch_addr,
   output logic                 fetch_valid,
   output logic [WORD_SIZE-1:0] instr,
   input  logic                 data_req,
   input  logic                 data_we,
   input  logic [WORD_SIZE-1:0] data_addr,
   input  logic [WORD_SIZE-1:0] data_wdata,
   output logic                 data_done,
   output logic [WORD_SIZE-1:0] data_rdata,
   output logic                 busy,
   output logic                 mem_err,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   input  logic                 ackOutput
);

   state_e               state_q, state_d;
   kind_e                kind_q, kind_d;
   bus_req_t             req_q, req_d;
   logic [WORD_SIZE-1:0] instr_q, instr_d;
   logic [WORD_SIZE-1:0] rdata_q, rdata_d;
   logic                 fetch_valid_q, fetch_valid_d;
   logic                 data_done_q, data_done_d;
   logic                 readM_q, readM_d;
   logic                 writeM_q, writeM_d;
   logic                 busy_q, busy_d;
   logic [WORD_SIZE-1:0] address_q, address_d;
   logic                 handshake_c;
   logic                 expire_c;
   logic                 abort_c;

   assign handshake_c = ((state_q == ST_RD) && inputReady) ||
                        ((state_q == ST_WR) && ackOutput);
   assign abort_c     = expire_c && !handshake_c;

`ifdef MEM_TIMEOUT_EN
   logic mem_err_q;

   mem_timeout_counter #(
      .LIMIT    (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset_n  (reset_n),
      .clear_i  (state_q == ST_IDLE),
      .en_i     (state_q != ST_IDLE),
      .expire_c (expire_c)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem_err_q <= 1'b0;
      end else begin
         mem_err_q <= abort_c;
      end
   end

   assign mem_err = mem_err_q;
`else
   assign expire_c = 1'b0;
   assign mem_err  = 1'b0;
`endif

   // Next-state, capture and registered bus strobe decode.
   always_comb begin
      state_d       = state_q;
      kind_d        = kind_q;
      req_d         = req_q;
      instr_d       = instr_q;
      rdata_d       = rdata_q;
      fetch_valid_d = 1'b0;
      data_done_d   = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (data_req) begin
               req_d.addr  = data_addr;
               req_d.wdata = data_wdata;
               kind_d      = KIND_LOAD;
               state_d     = data_we ? ST_WR : ST_RD;
            end else if (fetch_req) begin
               req_d.addr = fetch_addr;
               kind_d     = KIND_FETCH;
               state_d    = ST_RD;
            end
         end
         ST_RD: begin
            if (handshake_c || abort_c) begin
               state_d = ST_IDLE;
               if (kind_q == KIND_FETCH) begin
                  fetch_valid_d = 1'b1;
                  if (handshake_c) instr_d = data;
               end else begin
                  data_done_d = 1'b1;
                  if (handshake_c) rdata_d = data;
               end
            end
         end
         ST_WR: begin
            if (handshake_c || abort_c) begin
               state_d     = ST_IDLE;
               data_done_d = 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      readM_d   = (state_d == ST_RD);
      writeM_d  = (state_d == ST_WR);
      busy_d    = (state_d != ST_IDLE);
      address_d = (state_d == ST_IDLE) ? '0 : req_d.addr;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         kind_q        <= KIND_FETCH;
         req_q         <= '0;
         instr_q       <= '0;
         rdata_q       <= '0;
         fetch_valid_q <= 1'b0;
         data_done_q   <= 1'b0;
         readM_q       <= 1'b0;
         writeM_q      <= 1'b0;
         busy_q        <= 1'b0;
         address_q     <= '0;
      end else begin
         state_q       <= state_d;
         kind_q        <= kind_d;
         req_q         <= req_d;
         instr_q       <= instr_d;
         rdata_q       <= rdata_d;
         fetch_valid_q <= fetch_valid_d;
         data_done_q   <= data_done_d;
         readM_q       <= readM_d;
         writeM_q      <= writeM_d;
         busy_q        <= busy_d;
         address_q     <= address_d;
      end
   end

   // Bus driver enable comes straight from a flop so the data pins never glitch on.
   assign data        = writeM_q ? req_q.wdata : {WORD_SIZE{1'bz}};

   assign fetch_valid = fetch_valid_q;
   assign data_done   = data_done_q;
   assign instr       = instr_q;
   assign data_rdata  = rdata_q;
   assign readM       = readM_q;
   assign writeM      = writeM_q;
   assign busy        = busy_q;
   assign address     = address_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomised scoreboard bench for mem_access_unit: a driver issues core requests and
// records expectations from an in-order memory model; a bus-side process responds and checks.
module tb_mem_access_unit;

   localparam int unsigned TO = 4;

   typedef struct {
      int          kind;   // 0 fetch, 1 load, 2 store
      logic [15:0] addr;
      logic [15:0] val;
      logic        err;
   } exp_t;

   logic        clk;
   logic        reset_n;
   logic        fetch_req, data_req, data_we;
   logic [15:0] fetch_addr, data_addr, data_wdata;
   logic        fetch_valid, data_done, busy, mem_err, readM, writeM;
   logic [15:0] instr, data_rdata, address;
   logic        inputReady, ackOutput;
   logic        mem_oe;
   logic [15:0] mem_drv;
   wire  [15:0] data;

   int          n_tests = 0;
   int          n_fail  = 0;
   exp_t        exp_q[$];
   logic [15:0] ref_mem [256];
   logic [15:0] bus_mem [256];
   logic [15:0] ref_instr, ref_rdata;
   int          force_delay = -1;
   bit          no_resp = 1'b0;

   assign data = mem_oe ? mem_drv : 16'hzzzz;

`ifdef MEM_TIMEOUT_EN
   mem_access_unit #(.TIMEOUT_CYCLES(TO)) u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .instr       (instr),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_done   (data_done),
      .data_rdata  (data_rdata),
      .busy        (busy),
      .mem_err     (mem_err),
      .readM       (readM),
      .writeM      (writeM),
      .address     (address),
      .data        (data),
      .inputReady  (inputReady),
      .ackOutput   (ackOutput)
   );
`else
   mem_access_unit u_dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_valid (fetch_valid),
      .instr       (instr),
      .data_req    (data_req),
      .data_we     (data_we),
      .data_addr   (data_addr),
      .data_wdata  (data_wdata),
      .data_done   (data_done),
      .data_rdata  (data_rdata),
      .busy        (busy),
      .mem_err     (mem_err),
      .readM       (readM),
      .writeM      (writeM),
      .address     (address),
      .data        (data),
      .inputReady  (inputReady),
      .ackOutput   (ackOutput)
   );
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
      end
   endtask

   // Reference model: accesses complete in issue order against a flat memory image.
   function automatic void model_issue(input int kind, input logic [15:0] addr,
                                       input logic [15:0] wd, input logic err);
      exp_t e;
      e.kind = kind;
      e.addr = addr;
      e.err  = err;
      e.val  = wd;
      if (kind == 0) begin
         if (!err) ref_instr = ref_mem[addr[7:0]];
         e.val = ref_instr;
      end else if (kind == 1) begin
         if (!err) ref_rdata = ref_mem[addr[7:0]];
         e.val = ref_rdata;
      end else if (!err) begin
         ref_mem[addr[7:0]] = wd;
      end
      exp_q.push_back(e);
   endfunction

   task automatic wait_busy();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!busy && n < 40);
      if (!busy) check("wait_busy_timeout", 32'd0, 32'd1);
   endtask

   // Waits for a completion pulse; optionally wiggles the ignored request inputs meanwhile.
   task automatic wait_pulse(input bit junk);
      int n = 0;
      forever begin
         @(negedge clk);
         n++;
         if (fetch_valid || data_done) begin
            if (junk) begin fetch_req = 1'b0; data_req = 1'b0; end
            break;
         end
         if (n >= 60) begin
            check("wait_pulse_timeout", 32'd0, 32'd1);
            fetch_req = 1'b0;
            data_req  = 1'b0;
            break;
         end
         if (junk) begin
            fetch_req  = 1'($urandom);
            data_req   = 1'($urandom);
            data_we    = 1'($urandom);
            fetch_addr = 16'($urandom);
            data_addr  = 16'($urandom);
            data_wdata = 16'($urandom);
         end
      end
   endtask

   task automatic do_op(input int kind, input logic [15:0] addr, input logic [15:0] wd,
                        input logic err);
      model_issue(kind, addr, wd, err);
      if (kind == 0) begin
         fetch_req  = 1'b1;
         fetch_addr = addr;
      end else begin
         data_req   = 1'b1;
         data_we    = (kind == 2);
         data_addr  = addr;
         data_wdata = wd;
      end
      wait_busy();
      fetch_req = 1'b0;
      data_req  = 1'b0;
      wait_pulse(1'b1);
   endtask

   task automatic do_collide(input logic [15:0] la, input logic [15:0] fa);
      model_issue(1, la, 16'h0, 1'b0);
      model_issue(0, fa, 16'h0, 1'b0);
      fetch_req  = 1'b1;
      fetch_addr = fa;
      data_req   = 1'b1;
      data_we    = 1'b0;
      data_addr  = la;
      wait_busy();
      data_req = 1'b0;
      wait_pulse(1'b0);
      wait_busy();
      fetch_req = 1'b0;
      wait_pulse(1'b1);
   endtask

   // Memory responder plus output monitor / scoreboard.
   initial begin
      int   scnt = 0;
      int   dly  = 0;
      int   last_len = 0;
      bit   hs;
      logic [15:0] last_addr = 16'h0;
      logic [15:0] last_wdata = 16'h0;
      exp_t e;
      inputReady = 1'b0;
      ackOutput  = 1'b0;
      mem_oe     = 1'b0;
      mem_drv    = 16'h0;
      forever begin
         @(negedge clk);
         if (readM || writeM) begin
            if (scnt == 0) dly = (force_delay >= 0) ? force_delay : int'($urandom_range(0, 2));
            hs = !no_resp && (scnt == dly);
            if (readM) begin
               ackOutput  = 1'b0;
               inputReady = hs;
               mem_oe     = 1'b1;
               mem_drv    = hs ? bus_mem[address[7:0]] : 16'($urandom);
               if (hs) last_addr = address;
            end else begin
               inputReady = 1'b0;
               mem_oe     = 1'b0;
               ackOutput  = hs;
               if (hs) begin
                  bus_mem[address[7:0]] = data;
                  last_addr  = address;
                  last_wdata = data;
               end
            end
            scnt++;
         end else begin
            if (scnt != 0) last_len = scnt;
            scnt       = 0;
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            mem_oe     = 1'b0;
         end

         if (reset_n) begin
            check("busy_vs_strobe", 32'(busy), 32'(readM | writeM));
            if (!readM && !writeM) check("idle_address", 32'(address), 32'h0);
            if (writeM && exp_q.size() > 0 && exp_q[0].kind == 2)
               check("write_bus_data", 32'(data), 32'(exp_q[0].val));
            if (fetch_valid || data_done || mem_err) begin
               check("pulse_onehot", 32'(fetch_valid & data_done), 32'h0);
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse", {29'h0, fetch_valid, data_done, mem_err}, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_kind", {30'h0, fetch_valid, data_done},
                        (e.kind == 0) ? 32'h2 : 32'h1);
                  check("mem_err", 32'(mem_err), 32'(e.err));
                  check("strobe_len", 32'(last_len), e.err ? TO : 32'(dly + 1));
                  check("strobe_off_at_pulse", 32'(readM | writeM), 32'h0);
                  if (!e.err) check("bus_address", 32'(last_addr), 32'(e.addr));
                  if (e.kind == 0)      check("instr", 32'(instr), 32'(e.val));
                  else if (e.kind == 1) check("data_rdata", 32'(data_rdata), 32'(e.val));
                  else                  check("store_data", 32'(last_wdata), 32'(e.val));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got hang, required completion");
      $fatal(1, "watchdog");
   end

   // Driver: directed cases, then randomised traffic, then reset mid-read.
   initial begin
      int          op;
      int          n;
      logic [15:0] a, b;
      fetch_req  = 1'b0;
      data_req   = 1'b0;
      data_we    = 1'b0;
      fetch_addr = 16'h0;
      data_addr  = 16'h0;
      data_wdata = 16'h0;
      ref_instr  = 16'h0;
      ref_rdata  = 16'h0;
      for (int i = 0; i < 256; i++) begin
         ref_mem[i] = 16'(i * 16'h1357) ^ 16'hA5A5;
         bus_mem[i] = ref_mem[i];
      end
      ref_mem[8'h10] = 16'h6A01;
      bus_mem[8'h10] = 16'h6A01;

      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      #1;
      check("rst_readM", 32'(readM), 32'h0);
      check("rst_writeM", 32'(writeM), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_address", 32'(address), 32'h0);
      check("rst_pulses", {29'h0, fetch_valid, data_done, mem_err}, 32'h0);
      check("rst_instr", 32'(instr), 32'h0);
      check("rst_rdata", 32'(data_rdata), 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      force_delay = 2;
      do_op(0, 16'h0010, 16'h0, 1'b0);
      force_delay = 1;
      do_op(2, 16'h0040, 16'hBEEF, 1'b0);
      force_delay = -1;
      do_collide(16'h0041, 16'h0012);
      do_op(1, 16'h0040, 16'h0, 1'b0);

`ifdef MEM_TIMEOUT_EN
      no_resp = 1'b1;
      do_op(0, 16'h0020, 16'h0, 1'b1);
      no_resp = 1'b0;
      force_delay = int'(TO) - 1;
      do_op(0, 16'h0021, 16'h0, 1'b0);
      force_delay = -1;
`endif

      for (int i = 0; i < 300; i++) begin
         op = int'($urandom_range(0, 3));
         a  = 16'($urandom_range(0, 63));
         b  = 16'($urandom_range(0, 63));
         if (op == 3) do_collide(a, b);
         else         do_op(op, a, 16'($urandom), 1'b0);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end

      // Reset while a read handshake is pending.
      force_delay = 2;
      fetch_req   = 1'b1;
      fetch_addr  = 16'h0033;
      wait_busy();
      fetch_req = 1'b0;
      n = 0;
      while (!inputReady && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("reset_test_ready_seen", 32'(inputReady), 32'h1);
      #2 reset_n = 1'b0;
      #1;
      exp_q.delete();
      ref_instr = 16'h0;
      ref_rdata = 16'h0;
      check("midrst_readM", 32'(readM), 32'h0);
      check("midrst_writeM", 32'(writeM), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_address", 32'(address), 32'h0);
      check("midrst_pulses", {29'h0, fetch_valid, data_done, mem_err}, 32'h0);
      check("midrst_instr", 32'(instr), 32'h0);
      check("midrst_rdata", 32'(data_rdata), 32'h0);
      force_delay = -1;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      do_op(0, 16'h0010, 16'h0, 1'b0);
      do_op(1, 16'h0041, 16'h0, 1'b0);
      repeat (3) @(negedge clk);
      check("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
